// File: rtl/truth_table_sweeper.sv
// Exhaustive self-checking sweep of a combinational block:
// steps vec through every input pattern, samples f_in, tallies mismatches.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int DWELL = 10,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'b1110_1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_valid
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          smp;
  logic          last_vec;
  logic          miss;
  logic [N_IN:0] err_nxt;

  // f_in is only trusted on the final cycle of each dwell
  assign smp = (state == RUN) && (cnt == CW'(DWELL - 1));
  assign last_vec = (vec == {N_IN{1'b1}});
  assign miss = (f_in != EXPECTED[vec]);
  assign err_nxt = err_count + (N_IN+1)'(miss);

  assign busy = (state == RUN);
  assign done = (state == FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                state_nxt = IDLE;
        else if (smp && last_vec) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec              <= '0;
      cnt              <= '0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vec              <= '0;
            cnt              <= '0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            vec  <= '0;
            cnt  <= '0;
            pass <= 1'b0;
          end else if (smp) begin
            cnt <= '0;
            if (miss) begin
              err_count <= err_nxt;
              if (!first_fail_valid) begin
                first_fail_idx   <= vec;
                first_fail_valid <= 1'b1;
              end
            end
            if (last_vec) pass <= (err_nxt == '0);
            else          vec  <= vec + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          vec <= '0;
          cnt <= '0;
        end
        default: begin
          vec <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper driving a modelled 3-input
// majority block with selectable fault modes.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] vec;
  logic       f_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;
  logic       first_fail_valid;

  truth_table_sweeper dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .vec(vec),
    .f_in(f_in),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int pass;
    int err;
    int ffi;
    int ffv;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mode = 0;
  int   pos = 0;
  logic maj;

  always @(posedge clk) cyc <= cyc + 1;

  // dwell position seen by the modelled DUT, for the glitch mode
  always @(posedge clk or posedge rst) begin
    if (rst)       pos <= 0;
    else if (!busy) pos <= 0;
    else           pos <= (pos == 9) ? 0 : pos + 1;
  end

  // 0 correct, 1 inverted, 2 wrong at 5 and 6, 3 wrong except last dwell cycle
  always_comb begin
    maj = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    f_in = maj;
    case (mode)
      1: f_in = ~maj;
      2: f_in = maj ^ ((vec == 3'd5) || (vec == 3'd6));
      3: f_in = maj ^ (pos != 9);
      default: f_in = maj;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("pass", int'(pass), e.pass);
        chk("err_count", int'(err_count), e.err);
        chk("first_fail_idx", int'(first_fail_idx), e.ffi);
        chk("first_fail_valid", int'(first_fail_valid), e.ffv);
        chk("busy_in_finish", int'(busy), 0);
      end
    end
  end

  // pulse start for one edge; optionally queue the expected result
  task automatic do_start(input bit push, input int p, input int e,
                          input int fi, input int fv);
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (push) begin
      x.cyc = cyc + 80;
      x.pass = p;
      x.err = e;
      x.ffi = fi;
      x.ffv = fv;
      q.push_back(x);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("rst_vec", int'(vec), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_ffv", int'(first_fail_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // clean sweep, with a redundant start at cycle 30
    mode = 0;
    do_start(1'b1, 1, 0, 0, 0);
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) @(negedge clk);
      chk("run_busy", int'(busy), 1);
      chk("run_vec", int'(vec), (k - 1) / 10);
      start = (k == 30);
    end
    start = 1'b0;
    drain();
    chk("idle_pass_hold", int'(pass), 1);
    chk("idle_vec", int'(vec), 0);

    mode = 1;
    do_start(1'b1, 0, 8, 0, 1);
    drain();

    mode = 2;
    do_start(1'b1, 0, 2, 5, 1);
    drain();
    chk("hold_ffi", int'(first_fail_idx), 5);

    mode = 3;
    do_start(1'b1, 1, 0, 0, 0);
    drain();

    // abort on cycle 45
    mode = 0;
    do_start(1'b0, 0, 0, 0, 0);
    repeat (44) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_vec", int'(vec), 0);
    repeat (100) @(negedge clk);
    chk("abort_idle", int'(busy), 0);

    // asynchronous reset on cycle 50
    do_start(1'b0, 0, 0, 0, 0);
    repeat (49) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_vec", int'(vec), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_pass", int'(pass), 0);
    chk("async_err", int'(err_count), 0);
    @(negedge clk);
    rst = 1'b0;
    do_start(1'b1, 1, 0, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
